// File: rtl/lynxTypes.sv
// Shared partial-reconfiguration types: ICAP word width, ICAP streamer FSM states
// and the per-byte bit-order helper the ICAP primitive expects.
package lynxTypes;

  localparam int ICAP_DATA_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_WAIT_EOS = 2'd3
  } pr_icap_state_t;

  // ICAP consumes each byte MSB-first relative to the bitstream file, so mirror bits inside every byte.
  function automatic logic [ICAP_DATA_BITS-1:0] icap_bitswap(input logic [ICAP_DATA_BITS-1:0] w);
    logic [ICAP_DATA_BITS-1:0] r;
    r = '0;
    for (int b = 0; b < ICAP_DATA_BITS / 8; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[b*8 + i] = w[b*8 + 7 - i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pr_icap_streamer_eos_timer.sv
// End-of-startup countdown: loaded with the wait time, counts down while running,
// and raises a registered one-cycle eos on the cycle the count reads zero.
module pr_eos_timer (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        i_load,
  input  logic [31:0] i_eos_time,
  input  logic        i_run,
  output logic        o_eos
);

  logic [31:0] r_cnt;
  logic        r_eos;

  // Countdown register; the pulse is pre-computed one cycle early so it lines up with count == 0
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt <= 32'd0;
      r_eos <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_eos_time;
      r_eos <= (i_eos_time == 32'd0);
    end else if (i_run && (r_cnt != 32'd0)) begin
      r_cnt <= r_cnt - 32'd1;
      r_eos <= (r_cnt == 32'd1);
    end else begin
      r_cnt <= r_cnt;
      r_eos <= 1'b0;
    end
  end

  assign o_eos = r_eos;

endmodule

// File: rtl/pr_icap_streamer.sv
// Streams DMA bitstream beats into ICAP one 32-bit word per cycle and signals end-of-startup.
// Optional word counter on icap_words is built only when PR_ICAP_WORD_CNT_EN is defined.
module pr_icap_streamer
  import lynxTypes::*;
#(
  parameter int DATA_BITS = 512
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_dma_done,
  input  logic                 s_dma_last,
  input  logic [31:0]          eos_time,
  output logic                 icap_csib,
  output logic                 icap_rdwrb,
  output logic [31:0]          icap_i,
  output logic                 eos,
  output logic                 busy,
  output logic [31:0]          icap_words
);

  localparam int WORDS = DATA_BITS / ICAP_DATA_BITS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  pr_icap_state_t r_state;
  pr_icap_state_t w_next;

  logic [WORDS-1:0][ICAP_DATA_BITS-1:0] r_buf;
  logic [IDX_W-1:0]                     r_idx;
  logic                                 r_last_pending;
  logic                                 w_last_word;
  logic                                 w_accept;
  logic                                 w_eos;

  assign w_last_word = (r_idx == LAST_IDX);
  assign w_accept    = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)            w_next = ST_SHIFT;
        else if (r_last_pending) w_next = ST_DRAIN;
        else                     w_next = ST_IDLE;
      end
      ST_SHIFT: begin
        if (!w_last_word)        w_next = ST_SHIFT;
        else if (w_accept)       w_next = ST_SHIFT;
        else if (r_last_pending) w_next = ST_DRAIN;
        else                     w_next = ST_IDLE;
      end
      ST_DRAIN: begin
        w_next = ST_WAIT_EOS;
      end
      ST_WAIT_EOS: begin
        if (w_eos) w_next = ST_IDLE;
        else       w_next = ST_WAIT_EOS;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // tready is gated by aresetn so the DMA never sees an acceptance while reset is held
  always_comb begin
    s_axis_tready = 1'b0;
    icap_csib     = 1'b1;
    icap_i        = 32'd0;
    case (r_state)
      ST_IDLE: begin
        s_axis_tready = aresetn;
      end
      ST_SHIFT: begin
        s_axis_tready = aresetn & w_last_word;
        icap_csib     = 1'b0;
        icap_i        = icap_bitswap(r_buf[r_idx]);
      end
      ST_DRAIN, ST_WAIT_EOS: begin
        s_axis_tready = 1'b0;
      end
      default: begin
        s_axis_tready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_buf <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_buf <= s_axis_tdata;
      r_idx <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_buf <= r_buf;
      r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_buf <= r_buf;
      r_idx <= r_idx;
    end
  end

  // A new done+last wins over a same-cycle eos so a back-to-back bitstream is not lost
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_last_pending <= 1'b0;
    end else if (s_dma_done && s_dma_last) begin
      r_last_pending <= 1'b1;
    end else if (w_eos) begin
      r_last_pending <= 1'b0;
    end else begin
      r_last_pending <= r_last_pending;
    end
  end

  pr_eos_timer u_eos_timer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_load     (r_state == ST_DRAIN),
    .i_eos_time (eos_time),
    .i_run      (r_state == ST_WAIT_EOS),
    .o_eos      (w_eos)
  );

  assign eos        = w_eos;
  assign busy       = (r_state != ST_IDLE);
  assign icap_rdwrb = 1'b0;

`ifdef PR_ICAP_WORD_CNT_EN
  logic [31:0] r_words;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_words <= 32'd0;
    end else if (w_eos) begin
      r_words <= 32'd0;
    end else if (r_state == ST_SHIFT) begin
      r_words <= r_words + 32'd1;
    end else begin
      r_words <= r_words;
    end
  end

  assign icap_words = w_eos ? 32'd0 : r_words;
`else
  assign icap_words = 32'd0;
`endif

endmodule

// File: tb/tb_pr_icap_streamer.sv
// Self-checking bench for pr_icap_streamer: table of stream/eos scenarios plus
// hand-written eos_time=0 stall, mid-beat reset and done-without-last sequences.
module tb_pr_icap_streamer;

  localparam int DATA_BITS = 512;
  localparam int WORDS     = DATA_BITS / 32;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic [DATA_BITS-1:0] s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 s_dma_done;
  logic                 s_dma_last;
  logic [31:0]          eos_time;
  logic                 icap_csib;
  logic                 icap_rdwrb;
  logic [31:0]          icap_i;
  logic                 eos;
  logic                 busy;
  logic [31:0]          icap_words;

  always #5 aclk = ~aclk;

  pr_icap_streamer #(.DATA_BITS(DATA_BITS)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_dma_done    (s_dma_done),
    .s_dma_last    (s_dma_last),
    .eos_time      (eos_time),
    .icap_csib     (icap_csib),
    .icap_rdwrb    (icap_rdwrb),
    .icap_i        (icap_i),
    .eos           (eos),
    .busy          (busy),
    .icap_words    (icap_words)
  );

  typedef struct {
    int          n_beats;
    bit          send_last;
    logic [31:0] eos_t;
    bit          rnd;
    int          exp_run_words;
    int          exp_eos;
    int          exp_delay;
  } vec_t;

  vec_t        vecs[5];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          n_words = 0;
  int          first_cyc = -1;
  int          last_cyc = -1;
  int          n_eos = 0;
  int          eos_cyc = -1;
  logic [31:0] model_wc = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rev(input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  b;
    for (int i = 0; i < 4; i++) begin
      b = w[i*8 +: 8];
      r[i*8 +: 8] = {<<{b}};
    end
    return r;
  endfunction

  function automatic logic [31:0] wc_exp(input logic [31:0] v);
`ifdef PR_ICAP_WORD_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  function automatic logic [DATA_BITS-1:0] make_beat(input logic [31:0] base, input bit rnd);
    logic [DATA_BITS-1:0] d;
    for (int k = 0; k < WORDS; k++) begin
      d[k*32 +: 32] = rnd ? $urandom() : base + 32'(k + 1);
    end
    return d;
  endfunction

  // Monitor: every ICAP word is popped from the scoreboard in order
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (icap_csib === 1'b0) begin
        n_words++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        chk("icap_rdwrb", 32'(icap_rdwrb), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stray_word: got 0x%08h expected no word", icap_i);
        end else begin
          chk("icap_i", icap_i, exp_q.pop_front());
        end
      end
      if (eos === 1'b1) begin
        n_eos++;
        eos_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    n_words   = 0;
    first_cyc = -1;
    last_cyc  = -1;
    n_eos     = 0;
    eos_cyc   = -1;
  endtask

  task automatic offer_beat(input logic [DATA_BITS-1:0] d);
    int t;
    t = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (s_axis_tready !== 1'b1 && t < 300) begin
      @(negedge aclk);
      t++;
    end
    if (s_axis_tready !== 1'b1) begin
      chk("accept_timeout", 32'(s_axis_tready), 32'd1);
      s_axis_tvalid = 1'b0;
    end else begin
      for (int k = 0; k < WORDS; k++) exp_q.push_back(ref_rev(d[k*32 +: 32]));
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic pulse_done(input logic lst);
    @(posedge aclk);
    #1;
    s_dma_done = 1'b1;
    s_dma_last = lst;
    @(posedge aclk);
    #1;
    s_dma_done = 1'b0;
    s_dma_last = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    @(negedge aclk);
    while (busy === 1'b1 && t < bound) begin
      @(negedge aclk);
      t++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [DATA_BITS-1:0] d2;

    vecs[0] = '{1, 1'b0, 32'd0, 1'b0, 16, 0, 0};
    vecs[1] = '{3, 1'b0, 32'd7, 1'b1, 48, 0, 0};
    vecs[2] = '{2, 1'b1, 32'd5, 1'b0, 32, 1, 7};
    vecs[3] = '{1, 1'b1, 32'd0, 1'b1, 16, 1, 2};
    vecs[4] = '{2, 1'b1, 32'd3, 1'b1, 32, 1, 5};

    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_dma_done    = 1'b0;
    s_dma_last    = 1'b0;
    eos_time      = 32'd0;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_csib", 32'(icap_csib), 32'd1);
    chk("rst_rdwrb", 32'(icap_rdwrb), 32'd0);
    chk("rst_icap_i", icap_i, 32'd0);
    chk("rst_eos", 32'(eos), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_words", icap_words, 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("idle_tready", 32'(s_axis_tready), 32'd1);

    for (int r = 0; r < 5; r++) begin
      eos_time = vecs[r].eos_t;
      clear_stats();
      for (int b = 0; b < vecs[r].n_beats; b++) begin
        offer_beat(make_beat(32'h100 * 32'(r) * 32'(b + 1), vecs[r].rnd));
        if (vecs[r].send_last && b == vecs[r].n_beats - 1) begin
          repeat (5) @(posedge aclk);
          pulse_done(1'b1);
        end
      end
      wait_idle(400);
      chk("row_words", 32'(n_words), 32'(vecs[r].exp_run_words));
      chk("row_contig", 32'(last_cyc - first_cyc + 1), 32'(n_words));
      chk("row_queue", 32'(exp_q.size()), 32'd0);
      chk("row_eos_n", 32'(n_eos), 32'(vecs[r].exp_eos));
      if (vecs[r].exp_eos != 0) chk("row_eos_delay", 32'(eos_cyc - last_cyc), 32'(vecs[r].exp_delay));
      if (vecs[r].send_last) model_wc = 32'd0;
      else                   model_wc = model_wc + 32'(vecs[r].exp_run_words);
      chk("row_icap_words", icap_words, wc_exp(model_wc));
      chk("row_busy", 32'(busy), 32'd0);
    end

    // eos_time = 0 with a beat offered while draining: stalled, then streamed after eos
    eos_time = 32'd0;
    clear_stats();
    offer_beat(make_beat(32'h5000, 1'b0));
    repeat (4) @(posedge aclk);
    pulse_done(1'b1);
    begin
      int t;
      t = 0;
      @(negedge aclk);
      while (icap_csib !== 1'b1 && t < 40) begin
        @(negedge aclk);
        t++;
      end
    end
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_stall", 32'(s_axis_tready), 32'd0);
    d2 = make_beat(32'h6000, 1'b1);
    s_axis_tdata  = d2;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    chk("wait_eos_pulse", 32'(eos), 32'd1);
    chk("wait_stall", 32'(s_axis_tready), 32'd0);
    offer_beat(d2);
    wait_idle(400);
    chk("stall_words", 32'(n_words), 32'd32);
    chk("stall_eos_n", 32'(n_eos), 32'd1);
    chk("stall_queue", 32'(exp_q.size()), 32'd0);
    model_wc = 32'd16;
    chk("stall_icap_words", icap_words, wc_exp(model_wc));

    // Reset at word 7 with a pending last: beat abandoned, no eos afterwards
    eos_time = 32'd3;
    clear_stats();
    offer_beat(make_beat(32'h7000, 1'b1));
    s_dma_done = 1'b1;
    s_dma_last = 1'b1;
    @(posedge aclk);
    #1;
    s_dma_done = 1'b0;
    s_dma_last = 1'b0;
    repeat (6) @(posedge aclk);
    #1;
    chk("pre_reset_csib", 32'(icap_csib), 32'd0);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("mid_rst_csib", 32'(icap_csib), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tready", 32'(s_axis_tready), 32'd0);
    chk("mid_rst_words_seen", 32'(n_words), 32'd8);
    @(posedge aclk);
    #1;
    exp_q.delete();
    aresetn  = 1'b1;
    model_wc = 32'd0;
    repeat (40) @(posedge aclk);
    #1;
    chk("post_rst_no_eos", 32'(n_eos), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_icap_words", icap_words, 32'd0);
    clear_stats();
    offer_beat(make_beat(32'h8000, 1'b0));
    wait_idle(100);
    chk("post_rst_beat_words", 32'(n_words), 32'd16);
    chk("post_rst_queue", 32'(exp_q.size()), 32'd0);
    chk("post_rst_eos_n", 32'(n_eos), 32'd0);
    model_wc = 32'd16;
    chk("post_rst_wc", icap_words, wc_exp(model_wc));

    // done without last must not start an end-of-startup sequence
    clear_stats();
    pulse_done(1'b0);
    repeat (100) @(posedge aclk);
    #1;
    chk("done_only_eos", 32'(n_eos), 32'd0);
    chk("done_only_busy", 32'(busy), 32'd0);
    chk("done_only_words", 32'(n_words), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
